aunit_sched: RTL and testbench
==============================

AUNIT_SCHED -- requirements
Module: aunit_sched

Interface
REQ-001 SHALL have parameter AuMaskWd, default 48, Aunit operand/mask width (three 16-bit lane groups: 1b, 2b, 4b).
REQ-002 SHALL have parameter AuODWd, default 16, Aunit signed sum width.
REQ-003 SHALL have parameter AccWd, default 24, accumulator/result width, AccWd > AuODWd.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports i_cfg_rdy in 1, o_cfg_ack out 1, i_cfg_mode in 3, i_cfg_inumt in 1, i_cfg_wnumt in 1, i_cfg_len in 8: job configuration, beats = i_cfg_len+1 (1..256).
REQ-007 SHALL have ports i_src_rdy in 1, o_src_ack out 1, i_src_ipix in AuMaskWd, i_src_wpix in AuMaskWd: operand stream.
REQ-008 SHALL have ports o_au_work out 1, o_au_mode out 3, o_au_inumt out 1, o_au_wnumt out 1, o_au_mask out AuMaskWd: Aunit control.
REQ-009 SHALL have ports o_au_ipix/o_au_wpix out AuMaskWd, o_au_ipix_rdy/o_au_wpix_rdy out 1, o_au_ipix_zero/o_au_wpix_zero out 1, i_au_ipix_ack/i_au_wpix_ack in 1: Aunit operand handshake.
REQ-010 SHALL have ports i_au_sum in AuODWd (signed), i_au_sum_rdy in 1, o_au_sum_ack out 1: Aunit result handshake.
REQ-011 SHALL have ports o_res out AccWd (signed), o_res_rdy out 1, i_res_ack in 1, o_err out 1, i_abort in 1.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE, FLUSH.
REQ-013 Transfer on any rdy/ack pair SHALL occur only in a cycle where both are high.
REQ-014 IDLE: o_cfg_ack = i_cfg_rdy; on transfer latch mode/inumt/wnumt/len, clear accumulator and both counters, go RUN.
REQ-015 Mode encoding XNOR=0, M1=1, M2=2, M4=3; mode >= 4 on cfg transfer SHALL pulse o_err one cycle and remain IDLE.
REQ-016 o_au_mask SHALL be bits[15:0] set for XNOR/M1, bits[31:16] for M2, bits[47:32] for M4, all zero in IDLE.
REQ-017 o_au_ipix/o_au_wpix SHALL be combinational pass-through of i_src_ipix/i_src_wpix.
REQ-018 RUN: o_au_ipix_rdy = o_au_wpix_rdy = i_src_rdy while issued count < beats, else 0; o_au_*_zero = 1 whenever rdy driven 1; o_src_ack = i_au_ipix_ack & i_au_wpix_ack.
REQ-019 Each src transfer SHALL increment the issue counter (9 bit); when issue count reaches beats, go DRAIN.
REQ-020 RUN and DRAIN: o_au_sum_ack = 1; each cycle with i_au_sum_rdy SHALL add sign-extended i_au_sum to accumulator and increment the retire counter.
REQ-021 Accumulation SHALL wrap modulo 2^AccWd; no saturation.
REQ-022 When retire count reaches beats (same-cycle issue and retire both counted), go DONE next cycle.
REQ-023 DONE: o_res_rdy = 1, o_res = accumulator, held stable until i_res_ack; on transfer go IDLE.
REQ-024 o_au_work SHALL be 1 in RUN, DRAIN, FLUSH; 0 in IDLE, DONE.
REQ-025 o_au_mode/inumt/wnumt SHALL hold latched config from cfg transfer until next cfg transfer.
REQ-026 i_abort in RUN/DRAIN/DONE SHALL go FLUSH next cycle, dropping o_res_rdy; in IDLE it is ignored.
REQ-027 FLUSH: one cycle, operand rdy = 0, o_au_sum_ack = 1, any sum discarded; then IDLE with accumulator cleared.
REQ-028 No cfg transfer SHALL occur outside IDLE.

Reset
REQ-029 On i_rstn low: state IDLE, counters 0, accumulator 0, latched mode XNOR, o_res_rdy/o_err/o_au_work/o_cfg_ack/o_src_ack/o_au_*_rdy/o_au_*_zero/o_au_sum_ack = 0, o_res = 0.
REQ-030 Reset mid-job SHALL abandon the job with no result produced after release.

Verification
REQ-031 M4 unsigned, len=0, ipix 4b lanes = 3, wpix 4b lanes = 2 (real Aunit) -> o_res = 24, o_res_rdy within 3 cycles of src transfer.
REQ-032 XNOR, len=3, ipix = ~wpix every beat -> o_res = -64 (24'hFFFFC0) after 4 beats.
REQ-033 M2 signed, len=255, i_src_rdy toggled randomly, i_res_ack delayed 5 cycles -> exactly 256 src transfers, o_res matches model, o_res stable while waiting.
REQ-034 cfg mode=5 -> o_err one-cycle pulse, o_au_work stays 0, state IDLE.
REQ-035 i_abort at beat 10 of len=20 -> one FLUSH cycle, no o_res_rdy; next job len=0 returns correct single-beat sum.
REQ-036 i_rstn low during DRAIN -> all outputs at reset values asynchronously, no o_res_rdy after release.

Source files
------------

// File: rtl/aunit_sched.sv
// Aunit job scheduler: accepts a job configuration, streams operand beats to the
// Aunit, accumulates the returned signed sums and presents the job result.
module aunit_sched #(
  parameter int AuMaskWd = 48,
  parameter int AuODWd   = 16,
  parameter int AccWd    = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_cfg_rdy,
  output logic                     o_cfg_ack,
  input  logic [2:0]               i_cfg_mode,
  input  logic                     i_cfg_inumt,
  input  logic                     i_cfg_wnumt,
  input  logic [7:0]               i_cfg_len,
  input  logic                     i_src_rdy,
  output logic                     o_src_ack,
  input  logic [AuMaskWd-1:0]      i_src_ipix,
  input  logic [AuMaskWd-1:0]      i_src_wpix,
  output logic                     o_au_work,
  output logic [2:0]               o_au_mode,
  output logic                     o_au_inumt,
  output logic                     o_au_wnumt,
  output logic [AuMaskWd-1:0]      o_au_mask,
  output logic [AuMaskWd-1:0]      o_au_ipix,
  output logic [AuMaskWd-1:0]      o_au_wpix,
  output logic                     o_au_ipix_rdy,
  output logic                     o_au_wpix_rdy,
  output logic                     o_au_ipix_zero,
  output logic                     o_au_wpix_zero,
  input  logic                     i_au_ipix_ack,
  input  logic                     i_au_wpix_ack,
  input  logic signed [AuODWd-1:0] i_au_sum,
  input  logic                     i_au_sum_rdy,
  output logic                     o_au_sum_ack,
  output logic signed [AccWd-1:0]  o_res,
  output logic                     o_res_rdy,
  input  logic                     i_res_ack,
  output logic                     o_err,
  input  logic                     i_abort
);

  localparam int LaneWd = AuMaskWd / 3;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FLUSH} state_t;
  typedef enum logic [2:0] {M_XNOR = 3'd0, M_M1 = 3'd1, M_M2 = 3'd2, M_M4 = 3'd3} mode_t;

  state_t           state;
  mode_t            mode;
  logic             inumt;
  logic             wnumt;
  logic [8:0]       beats;
  logic [8:0]       issued;
  logic [8:0]       retired;
  logic [AccWd-1:0] acc;
  logic             err;

  logic             issuing;
  logic             cfg_xfer;
  logic             src_xfer;
  logic             sum_xfer;
  logic [8:0]       issued_nxt;
  logic [8:0]       retired_nxt;
  logic [AccWd-1:0] sum_ext;

  assign issuing  = (state == RUN) && (issued < beats);
  // gated by reset so the handshake reads 0 while reset is held
  assign o_cfg_ack = i_rstn && (state == IDLE) && i_cfg_rdy;
  assign cfg_xfer  = i_cfg_rdy && o_cfg_ack;

  assign o_au_ipix      = i_src_ipix;
  assign o_au_wpix      = i_src_wpix;
  assign o_au_ipix_rdy  = issuing && i_src_rdy;
  assign o_au_wpix_rdy  = issuing && i_src_rdy;
  assign o_au_ipix_zero = issuing && i_src_rdy;
  assign o_au_wpix_zero = issuing && i_src_rdy;
  assign o_src_ack      = issuing && i_au_ipix_ack && i_au_wpix_ack;
  assign src_xfer       = i_src_rdy && o_src_ack;

  assign o_au_sum_ack = (state == RUN) || (state == DRAIN) || (state == FLUSH);
  assign sum_xfer     = i_au_sum_rdy && ((state == RUN) || (state == DRAIN));
  assign sum_ext      = {{(AccWd-AuODWd){i_au_sum[AuODWd-1]}}, i_au_sum};
  assign issued_nxt   = issued + {8'd0, src_xfer};
  assign retired_nxt  = retired + {8'd0, sum_xfer};

  assign o_au_work  = (state == RUN) || (state == DRAIN) || (state == FLUSH);
  assign o_au_mode  = mode;
  assign o_au_inumt = inumt;
  assign o_au_wnumt = wnumt;
  assign o_res_rdy  = (state == DONE);
  assign o_res      = (state == DONE) ? acc : '0;
  assign o_err      = err;

  always_comb begin
    o_au_mask = '0;
    if (state != IDLE) begin
      case (mode)
        M_M2:    o_au_mask[2*LaneWd-1:LaneWd]   = '1;
        M_M4:    o_au_mask[3*LaneWd-1:2*LaneWd] = '1;
        default: o_au_mask[LaneWd-1:0]          = '1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      mode    <= M_XNOR;
      inumt   <= 1'b0;
      wnumt   <= 1'b0;
      beats   <= '0;
      issued  <= '0;
      retired <= '0;
      acc     <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_xfer) begin
            if (i_cfg_mode[2]) begin
              err <= 1'b1;
            end else begin
              mode    <= mode_t'(i_cfg_mode);
              inumt   <= i_cfg_inumt;
              wnumt   <= i_cfg_wnumt;
              beats   <= {1'b0, i_cfg_len} + 9'd1;
              issued  <= '0;
              retired <= '0;
              acc     <= '0;
              state   <= RUN;
            end
          end
        end
        RUN, DRAIN: begin
          if (i_abort) begin
            state <= FLUSH;
          end else begin
            issued  <= issued_nxt;
            retired <= retired_nxt;
            if (sum_xfer) acc <= acc + sum_ext;
            // retire completion wins so a same-cycle last issue/retire skips DRAIN
            if (retired_nxt == beats)     state <= DONE;
            else if (issued_nxt == beats) state <= DRAIN;
          end
        end
        DONE: begin
          if (i_abort)        state <= FLUSH;
          else if (i_res_ack) state <= IDLE;
        end
        FLUSH: begin
          issued  <= '0;
          retired <= '0;
          acc     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aunit_sched.sv
// Bench for aunit_sched: behavioural Aunit plus a job-level reference sum,
// table-driven jobs, randomized jobs and abort / error / reset sequences.
module tb_aunit_sched;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_cfg_rdy = 1'b0;
  logic        o_cfg_ack;
  logic [2:0]  i_cfg_mode = '0;
  logic        i_cfg_inumt = 1'b0;
  logic        i_cfg_wnumt = 1'b0;
  logic [7:0]  i_cfg_len = '0;
  logic        i_src_rdy = 1'b0;
  logic        o_src_ack;
  logic [47:0] i_src_ipix = '0;
  logic [47:0] i_src_wpix = '0;
  logic        o_au_work;
  logic [2:0]  o_au_mode;
  logic        o_au_inumt;
  logic        o_au_wnumt;
  logic [47:0] o_au_mask;
  logic [47:0] o_au_ipix;
  logic [47:0] o_au_wpix;
  logic        o_au_ipix_rdy;
  logic        o_au_wpix_rdy;
  logic        o_au_ipix_zero;
  logic        o_au_wpix_zero;
  logic        i_au_ipix_ack = 1'b0;
  logic        i_au_wpix_ack = 1'b0;
  logic [15:0] i_au_sum = '0;
  logic        i_au_sum_rdy = 1'b0;
  logic        o_au_sum_ack;
  logic [23:0] o_res;
  logic        o_res_rdy;
  logic        i_res_ack = 1'b0;
  logic        o_err;
  logic        i_abort = 1'b0;

  always #5 i_clk = ~i_clk;

  aunit_sched #(.AuMaskWd(48), .AuODWd(16), .AccWd(24)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cfg_rdy(i_cfg_rdy), .o_cfg_ack(o_cfg_ack), .i_cfg_mode(i_cfg_mode),
    .i_cfg_inumt(i_cfg_inumt), .i_cfg_wnumt(i_cfg_wnumt), .i_cfg_len(i_cfg_len),
    .i_src_rdy(i_src_rdy), .o_src_ack(o_src_ack), .i_src_ipix(i_src_ipix), .i_src_wpix(i_src_wpix),
    .o_au_work(o_au_work), .o_au_mode(o_au_mode), .o_au_inumt(o_au_inumt), .o_au_wnumt(o_au_wnumt),
    .o_au_mask(o_au_mask), .o_au_ipix(o_au_ipix), .o_au_wpix(o_au_wpix),
    .o_au_ipix_rdy(o_au_ipix_rdy), .o_au_wpix_rdy(o_au_wpix_rdy),
    .o_au_ipix_zero(o_au_ipix_zero), .o_au_wpix_zero(o_au_wpix_zero),
    .i_au_ipix_ack(i_au_ipix_ack), .i_au_wpix_ack(i_au_wpix_ack),
    .i_au_sum(i_au_sum), .i_au_sum_rdy(i_au_sum_rdy), .o_au_sum_ack(o_au_sum_ack),
    .o_res(o_res), .o_res_rdy(o_res_rdy), .i_res_ack(i_res_ack),
    .o_err(o_err), .i_abort(i_abort)
  );

  int vectors = 0;
  int miscompares = 0;
  int nsrc = 0;
  int cyc = 0;
  int last_src = 0;
  bit rnd_hs = 1'b0;
  logic [47:0] q_ip[$];
  logic [47:0] q_wp[$];

  typedef struct {
    logic [2:0]  m;
    logic        isg;
    logic        wsg;
    logic [7:0]  len;
    logic [47:0] ip;
    logic [47:0] wp;
    bit          rnd;
    int          dly;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [47:0] v, input int base, input int w, input bit sg);
    int x;
    x = int'((v >> base) & ((48'd1 << w) - 48'd1));
    if (sg && x >= (1 << (w - 1))) x -= (1 << w);
    return x;
  endfunction

  // Aunit arithmetic: XNOR popcount (+1 match / -1 mismatch), or lane dot products.
  function automatic logic [15:0] dot(input logic [2:0] m, input logic isg, input logic wsg,
                                      input logic [47:0] ip, input logic [47:0] wp);
    int acc = 0;
    case (m)
      3'd0: for (int i = 0; i < 16; i++) acc += (ip[i] == wp[i]) ? 1 : -1;
      3'd1: for (int i = 0; i < 16; i++) acc += int'(ip[i] & wp[i]);
      3'd2: for (int k = 0; k < 8; k++) acc += lane(ip, 16 + 2*k, 2, isg) * lane(wp, 16 + 2*k, 2, wsg);
      3'd3: for (int k = 0; k < 4; k++) acc += lane(ip, 32 + 4*k, 4, isg) * lane(wp, 32 + 4*k, 4, wsg);
      default: acc = 0;
    endcase
    return 16'(acc);
  endfunction

  function automatic logic [23:0] model(input logic [2:0] m, input logic isg, input logic wsg);
    int total = 0;
    logic signed [15:0] v;
    for (int i = 0; i < q_ip.size(); i++) begin
      v = dot(m, isg, wsg, q_ip[i], q_wp[i]);
      total += int'(v);
    end
    return 24'(total);
  endfunction

  function automatic logic [47:0] mask_of(input logic [2:0] m);
    case (m)
      3'd2:    return 48'h0000_FFFF_0000;
      3'd3:    return 48'hFFFF_0000_0000;
      default: return 48'h0000_0000_FFFF;
    endcase
  endfunction

  // One clock: note transfers before the edge, then play source and Aunit after it.
  task automatic tick();
    logic sx, ox;
    logic [15:0] s;
    sx = i_src_rdy & o_src_ack;
    ox = o_au_ipix_rdy & o_au_wpix_rdy & i_au_ipix_ack & i_au_wpix_ack;
    s  = dot(o_au_mode, o_au_inumt, o_au_wnumt, o_au_ipix, o_au_wpix);
    @(posedge i_clk);
    #1;
    cyc++;
    if (sx) begin
      nsrc++;
      last_src = cyc;
      if (q_ip.size() > 0) begin
        void'(q_ip.pop_front());
        void'(q_wp.pop_front());
      end
    end
    i_au_sum_rdy = ox;
    i_au_sum     = ox ? s : 16'($urandom);
    if (q_ip.size() > 0) begin
      i_src_rdy  = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      i_src_ipix = q_ip[0];
      i_src_wpix = q_wp[0];
    end else begin
      i_src_rdy  = 1'b0;
      i_src_ipix = {16'($urandom), 32'($urandom)};
      i_src_wpix = {16'($urandom), 32'($urandom)};
    end
    i_au_ipix_ack = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_au_wpix_ack = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
  endtask

  task automatic start_job(input logic [2:0] m, input logic isg, input logic wsg,
                           input logic [7:0] len, input string name);
    nsrc = 0;
    i_cfg_mode = m; i_cfg_inumt = isg; i_cfg_wnumt = wsg; i_cfg_len = len;
    i_cfg_rdy = 1'b1;
    #1 check({name, "_cfg_ack"}, o_cfg_ack, 1);
    tick();
    i_cfg_rdy = 1'b0;
    #1;
    check({name, "_run"}, {o_au_work, o_au_mode, o_au_inumt, o_au_wnumt}, {1'b1, m, isg, wsg});
    check({name, "_mask"}, o_au_mask, mask_of(m));
    check({name, "_op_rdy"}, {o_au_ipix_rdy, o_au_wpix_rdy, o_au_ipix_zero, o_au_wpix_zero}, {4{i_src_rdy}});
  endtask

  task automatic run_job(input logic [2:0] m, input logic isg, input logic wsg, input logic [7:0] len,
                         input int dly, input logic [23:0] exp, input string name);
    int n;
    logic [23:0] hold;
    bit bad;
    start_job(m, isg, wsg, len, name);
    n = 0;
    while (!o_res_rdy && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_done"}, o_res_rdy, 1);
    check({name, "_nsrc"}, nsrc, int'(len) + 1);
    check({name, "_res"}, o_res, exp);
    if (len == 0 && !rnd_hs) check({name, "_lat"}, (cyc - last_src) <= 3, 1);
    bad = 1'b0;
    hold = o_res;
    repeat (dly) begin
      tick();
      if (o_res !== hold || o_res_rdy !== 1'b1) bad = 1'b1;
    end
    check({name, "_hold"}, bad, 0);
    i_res_ack = 1'b1;
    tick();
    i_res_ack = 1'b0;
    #1;
    check({name, "_idle"}, {o_res_rdy, o_au_work, o_au_mask}, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] m;
    logic isg, wsg;
    logic [7:0] len;
    logic [23:0] exp;
    bit bad;
    int n;

    tbl[0] = '{3'd3, 1'b0, 1'b0, 8'd0,   48'h3333_0000_0000, 48'h2222_0000_0000, 1'b0, 0, 24'h000018};
    tbl[1] = '{3'd0, 1'b0, 1'b0, 8'd3,   48'h0000_0000_A5A5, 48'h0000_0000_5A5A, 1'b0, 2, 24'hFFFFC0};
    tbl[2] = '{3'd1, 1'b0, 1'b0, 8'd1,   48'h0000_0000_FFFF, 48'h0000_0000_00FF, 1'b0, 0, 24'h000010};
    tbl[3] = '{3'd2, 1'b1, 1'b1, 8'd0,   48'h0000_FFFF_0000, 48'h0000_5555_0000, 1'b1, 1, 24'hFFFFF8};
    tbl[4] = '{3'd2, 1'b0, 1'b0, 8'd0,   48'h0000_FFFF_0000, 48'h0000_5555_0000, 1'b0, 0, 24'h000018};
    tbl[5] = '{3'd3, 1'b1, 1'b0, 8'd1,   48'hFFFF_0000_0000, 48'h7777_0000_0000, 1'b1, 3, 24'hFFFFC8};
    tbl[6] = '{3'd3, 1'b0, 1'b0, 8'd255, 48'hFFFF_0000_0000, 48'hFFFF_0000_0000, 1'b0, 0, 24'h038400};

    // reset values with handshake inputs pushed high
    i_cfg_rdy = 1'b1; i_src_rdy = 1'b1; i_au_ipix_ack = 1'b1; i_au_wpix_ack = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_ctl", {o_cfg_ack, o_src_ack, o_au_ipix_rdy, o_au_wpix_rdy, o_au_ipix_zero,
                        o_au_wpix_zero, o_au_sum_ack, o_au_work, o_res_rdy, o_err}, '0);
    check("reset_data", {o_res, o_au_mode, o_au_mask}, '0);
    i_cfg_rdy = 1'b0; i_src_rdy = 1'b0;
    i_rstn = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      q_ip.delete(); q_wp.delete();
      for (int b = 0; b <= int'(tbl[v].len); b++) begin
        q_ip.push_back(tbl[v].ip);
        q_wp.push_back(tbl[v].wp);
      end
      rnd_hs = tbl[v].rnd;
      run_job(tbl[v].m, tbl[v].isg, tbl[v].wsg, tbl[v].len, tbl[v].dly, tbl[v].exp, $sformatf("tbl%0d", v));
    end

    for (int j = 0; j < 7; j++) begin
      if (j == 6) begin
        m = 3'd2; isg = 1'b1; wsg = 1'b1; len = 8'd255;
      end else begin
        m = 3'($urandom_range(0, 3)); isg = 1'($urandom); wsg = 1'($urandom);
        len = 8'($urandom_range(0, 40));
      end
      q_ip.delete(); q_wp.delete();
      for (int b = 0; b <= int'(len); b++) begin
        q_ip.push_back({16'($urandom), 32'($urandom)});
        q_wp.push_back({16'($urandom), 32'($urandom)});
      end
      exp = model(m, isg, wsg);
      rnd_hs = 1'b1;
      run_job(m, isg, wsg, len, (j == 6) ? 5 : int'($urandom_range(0, 6)), exp, $sformatf("rnd%0d", j));
    end

    // invalid mode: error pulse, no job started; abort ignored while idle
    rnd_hs = 1'b0;
    i_cfg_mode = 3'd5; i_cfg_len = 8'd2; i_cfg_rdy = 1'b1;
    #1 check("badmode_ack", o_cfg_ack, 1);
    tick();
    i_cfg_rdy = 1'b0;
    check("badmode_err", {o_err, o_au_work}, 2'b10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("badmode_clear", {o_err, o_au_work}, 2'b00);
    tick();
    check("idle_abort", {o_au_work, o_res_rdy}, 2'b00);

    // abort mid-job, then a clean single-beat job
    q_ip.delete(); q_wp.delete();
    for (int b = 0; b < 21; b++) begin
      q_ip.push_back(48'h0000_0000_FFFF);
      q_wp.push_back(48'h0000_0000_FFFF);
    end
    start_job(3'd1, 1'b0, 1'b0, 8'd20, "abort");
    n = 0;
    while (nsrc < 10 && n < 200) begin
      tick();
      n++;
    end
    check("abort_beat10", nsrc, 10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    #1;
    check("abort_flush", {o_au_work, o_au_ipix_rdy, o_au_sum_ack, o_res_rdy}, 4'b1010);
    q_ip.delete(); q_wp.delete();
    tick();
    check("abort_idle", {o_au_work, o_res_rdy}, 2'b00);
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (o_res_rdy !== 1'b0) bad = 1'b1;
    end
    check("abort_no_res", bad, 0);
    q_ip.push_back(48'h3215_0000_0000);
    q_wp.push_back(48'h4444_0000_0000);
    run_job(3'd3, 1'b0, 1'b0, 8'd0, 0, 24'h00002C, "post_abort");

    // reset asserted while draining
    q_ip.delete(); q_wp.delete();
    for (int b = 0; b < 6; b++) begin
      q_ip.push_back(48'h0000_0000_00FF);
      q_wp.push_back(48'h0000_0000_0FFF);
    end
    start_job(3'd1, 1'b0, 1'b0, 8'd5, "drain");
    n = 0;
    while (nsrc < 6 && n < 200) begin
      tick();
      n++;
    end
    check("drain_work", {o_au_work, o_res_rdy}, 2'b10);
    i_src_rdy = 1'b1;
    #1 check("drain_no_issue", {o_au_ipix_rdy, o_src_ack}, 2'b00);
    i_rstn = 1'b0;
    i_cfg_rdy = 1'b1;
    #1;
    check("rst_async", {o_cfg_ack, o_src_ack, o_au_ipix_rdy, o_au_wpix_rdy, o_au_ipix_zero,
                        o_au_wpix_zero, o_au_sum_ack, o_au_work, o_res_rdy, o_err}, '0);
    check("rst_async_res", o_res, 0);
    i_cfg_rdy = 1'b0; i_src_rdy = 1'b0; i_au_sum_rdy = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (o_res_rdy !== 1'b0 || o_au_work !== 1'b0) bad = 1'b1;
    end
    check("rst_no_res", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
